// File: rtl/alioth_uart_loader.sv
// UART program loader: holds the core while ld_en=1, receives an 8N1 packet
// (A5, 4-byte LE length, payload, 8-bit sum) and writes the payload as 32-bit words.
module alioth_uart_loader #(
    parameter int          CLK_DIV   = 868,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        ld_en,
    output logic        core_hold,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err,
    output logic [2:0]  dbg_state
);
    localparam int          CW      = $clog2(CLK_DIV);
    localparam logic [CW-1:0] FULL  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [31:0] MAX_LEN = 32'(MAX_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // Byte interface between receiver and loader: byte_vld or frame_err pulse
    // for one cycle, rx_byte holds the received byte until the next frame.
    rx_state_t     rx_st;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bitn;
    logic [7:0]    rx_byte;
    logic          byte_vld, frame_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_st     <= R_IDLE;
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bitn      <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= uart_rx;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_st)
                R_IDLE: if (rx_prev && !rx_s2) begin
                    rx_st <= R_START;
                    cnt   <= '0;
                end
                R_START: if (cnt == HALF) begin
                    // a line that is high again at mid-start-bit was only a glitch
                    rx_st <= rx_s2 ? R_IDLE : R_DATA;
                    cnt   <= '0;
                    bitn  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                R_DATA: if (cnt == FULL) begin
                    rx_byte <= {rx_s2, rx_byte[7:1]};
                    cnt     <= '0;
                    bitn    <= bitn + 1'b1;
                    if (bitn == 3'd7) rx_st <= R_STOP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                R_STOP: if (cnt == FULL) begin
                    byte_vld  <= rx_s2;
                    frame_err <= !rx_s2;
                    rx_st     <= R_IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    state_t      state;
    logic [31:0] len, idx, wbuf, len_next, word_next;
    logic [7:0]  csum;
    logic [3:0]  wstrb_buf, strb_next;
    logic [1:0]  len_cnt, lane;
    logic        last_byte;

    always_comb begin
        lane      = idx[1:0];
        len_next  = {rx_byte, len[31:8]};
        word_next = wbuf | ({24'b0, rx_byte} << {lane, 3'b000});
        strb_next = wstrb_buf | (4'b0001 << lane);
        last_byte = (idx + 32'd1 == len);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            core_hold <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            len       <= '0;
            idx       <= '0;
            csum      <= '0;
            wbuf      <= '0;
            wstrb_buf <= '0;
            len_cnt   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (!ld_en) begin
                // leaving download mode drops any partial word without writing it
                state     <= S_IDLE;
                core_hold <= 1'b0;
                done      <= 1'b0;
                err       <= 1'b0;
                idx       <= '0;
                csum      <= '0;
                wbuf      <= '0;
                wstrb_buf <= '0;
                len_cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_HDR;
                        core_hold <= 1'b1;
                    end
                    S_HDR: if (byte_vld && rx_byte == 8'hA5) begin
                        state     <= S_LEN;
                        len_cnt   <= '0;
                        csum      <= '0;
                        idx       <= '0;
                        wbuf      <= '0;
                        wstrb_buf <= '0;
                    end
                    S_LEN: if (frame_err) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (byte_vld) begin
                        len     <= len_next;
                        len_cnt <= len_cnt + 1'b1;
                        if (len_cnt == 2'd3) begin
                            if (len_next > MAX_LEN) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                            end else if (len_next == 32'd0) begin
                                state <= S_CSUM;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: if (frame_err) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (byte_vld) begin
                        csum <= csum + rx_byte;
                        idx  <= idx + 32'd1;
                        if (lane == 2'd3 || last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= BASE_ADDR + {idx[31:2], 2'b00};
                            mem_wdata <= word_next;
                            mem_wstrb <= strb_next;
                            wbuf      <= '0;
                            wstrb_buf <= '0;
                        end else begin
                            wbuf      <= word_next;
                            wstrb_buf <= strb_next;
                        end
                        if (last_byte) state <= S_CSUM;
                    end
                    S_CSUM: if (frame_err) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end else if (byte_vld) begin
                        if (rx_byte == csum) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    S_DONE, S_ERR: ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule
